vid_mem_arbiter: RTL and testbench

VID_MEM_ARBITER -- requirements
Module: vid_mem_arbiter

---
 rtl/vid_mem_arbiter_pkg.sv | 18 +
 rtl/vid_addr_gen.sv | 35 +++
 rtl/vid_mem_arbiter.sv | 92 +++++++++
 tb/tb_vid_mem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vid_mem_arbiter_pkg.sv
// Shared types, defaults and byte-enable decode for the video/CPU SRAM arbiter.
package vid_mem_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int BURST_LEN_DEF   = 8;
   localparam int FRAME_WORDS_DEF = 24576;
   localparam int VPTR_W          = 15;

   // Byte accesses enable only the lane picked by the low address bits.
   function automatic logic [3:0] be_decode(input logic ben, input logic [1:0] lane);
      be_decode = ben ? (4'b0001 << lane) : 4'hF;
   endfunction

endpackage

// File: rtl/vid_addr_gen.sv
// Frame word pointer: steps once per video beat, wraps at the frame end and
// restarts at 0 on a pending frame sync, but only inside the clr window.
module vid_addr_gen
   import vid_mem_arbiter_pkg::*;
#(
   parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              clr,
   input  logic              step,
   output logic [VPTR_W-1:0] vptr
);

   logic sync_pend;

   // A sync seen in the same cycle as the clr window takes effect at once,
   // so a burst starting right after it begins at word 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         vptr      <= '0;
         sync_pend <= 1'b0;
      end else if (clr && (sync_pend || vsync)) begin
         vptr      <= '0;
         sync_pend <= 1'b0;
      end else begin
         sync_pend <= sync_pend | vsync;
         if (step) begin
            vptr <= (vptr == VPTR_W'(FRAME_WORDS - 1)) ? '0 : vptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vid_mem_arbiter.sv
// Single-port async SRAM shared between the CPU and display refresh.
// state | meaning
// IDLE  | CPU owns the SRAM; a sampled vreq starts a burst next cycle
// BURST | video owns the SRAM for BURST_LEN beats; CPU is stalled
module vid_mem_arbiter
   import vid_mem_arbiter_pkg::*;
#(
   parameter int BURST_LEN   = BURST_LEN_DEF,
   parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] adr,
   input  logic        rd,
   input  logic        wr,
   input  logic        ben,
   input  logic [31:0] outbus,
   output logic [31:0] inbus,
   output logic        stallX,
   input  logic        vreq,
   input  logic        vsync,
   input  logic [19:0] vbase,
   output logic [31:0] vdata,
   output logic        vvalid,
   output logic [19:0] sram_adr,
   output logic        sram_we,
   output logic [3:0]  sram_be,
   output logic [31:0] sram_dout,
   input  logic [31:0] sram_din
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   arb_state_t        state;
   logic [BEAT_W-1:0] beat;
   logic [VPTR_W-1:0] vptr;
   logic              in_burst;
   logic              unused_cpu;

   assign in_burst   = (state == BURST);
   assign unused_cpu = rd ^ (^adr[23:22]);

   vid_addr_gen #(
      .FRAME_WORDS(FRAME_WORDS)
   ) u_addr_gen (
      .clk  (clk),
      .rst  (rst),
      .vsync(vsync),
      .clr  (~in_burst),
      .step (in_burst),
      .vptr (vptr)
   );

   // Leaving BURST unconditionally guarantees the CPU one slot between bursts.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         beat   <= '0;
         vvalid <= 1'b0;
         vdata  <= '0;
      end else begin
         vvalid <= in_burst;
         if (in_burst) begin
            vdata <= sram_din;
         end
         case (state)
            IDLE: begin
               if (vreq) begin
                  state <= BURST;
                  beat  <= '0;
               end
            end
            BURST: begin
               if (beat == BEAT_W'(BURST_LEN - 1)) begin
                  state <= IDLE;
                  beat  <= '0;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
         endcase
      end
   end

   assign stallX    = in_burst;
   assign sram_adr  = in_burst ? (vbase + {{(20 - VPTR_W){1'b0}}, vptr}) : adr[21:2];
   assign sram_we   = ~in_burst & wr;
   assign sram_be   = in_burst ? 4'hF : be_decode(ben, adr[1:0]);
   assign sram_dout = outbus;
   assign inbus     = sram_din;

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Directed bench for vid_mem_arbiter: burst timing, CPU slot, byte enables,
// frame sync, pointer wrap and mid-burst reset.
module tb_vid_mem_arbiter;

   localparam int FW = 24576;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] adr = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic        ben = 1'b0;
   logic [31:0] outbus = '0;
   logic [31:0] inbus;
   logic        stallX;
   logic        vreq = 1'b0;
   logic        vsync = 1'b0;
   logic [19:0] vbase = 20'h10000;
   logic [31:0] vdata;
   logic        vvalid;
   logic [19:0] sram_adr;
   logic        sram_we;
   logic [3:0]  sram_be;
   logic [31:0] sram_dout;
   logic [31:0] sram_din;

   logic        vreq2 = 1'b0;
   logic        vsync2 = 1'b0;
   logic [19:0] vbase2 = 20'h00100;
   logic [31:0] inbus2;
   logic        stall2;
   logic [31:0] vdata2;
   logic        vvalid2;
   logic [19:0] sram_adr2;
   logic        sram_we2;
   logic [3:0]  sram_be2;
   logic [31:0] sram_dout2;
   logic [31:0] sram_din2;

   int n_chk = 0;
   int n_bad = 0;

   function automatic logic [31:0] word(input logic [19:0] a);
      word = {12'hA5A, a};
   endfunction

   assign sram_din  = word(sram_adr);
   assign sram_din2 = word(sram_adr2);

   always #5 clk = ~clk;

   vid_mem_arbiter u_dut (
      .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben),
      .outbus(outbus), .inbus(inbus), .stallX(stallX), .vreq(vreq),
      .vsync(vsync), .vbase(vbase), .vdata(vdata), .vvalid(vvalid),
      .sram_adr(sram_adr), .sram_we(sram_we), .sram_be(sram_be),
      .sram_dout(sram_dout), .sram_din(sram_din)
   );

   vid_mem_arbiter #(.BURST_LEN(8), .FRAME_WORDS(20)) u_wrap (
      .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben),
      .outbus(outbus), .inbus(inbus2), .stallX(stall2), .vreq(vreq2),
      .vsync(vsync2), .vbase(vbase2), .vdata(vdata2), .vvalid(vvalid2),
      .sram_adr(sram_adr2), .sram_we(sram_we2), .sram_be(sram_be2),
      .sram_dout(sram_dout2), .sram_din(sram_din2)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // One vreq pulse, then ten cycles watched: eight BURST beats plus two IDLE.
   // Expected addresses start at vbase + ptr0; vsync is optionally raised with
   // vreq or at cycle vs_at (cycle c is beat c-1).
   task automatic burst_watch(input int ptr0, input bit vs_req, input int vs_at);
      logic [19:0] ea;
      @(negedge clk);
      vreq  = 1'b1;
      vsync = vs_req;
      @(negedge clk);
      vreq  = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) @(negedge clk);
         vsync = (c == vs_at);
         wr    = (c <= 8);
         rd    = (c <= 8);
         ben   = 1'b0;
         adr   = 24'h000104;
         #1;
         check("stall", stallX, 32'(c <= 8));
         if (c <= 8) begin
            ea = vbase + 20'((ptr0 + c - 1) % FW);
            check("badr", sram_adr, ea);
            check("bwe", sram_we, 0);
            check("bbe", sram_be, 4'hF);
         end
         check("vvalid", vvalid, 32'(c >= 2 && c <= 9));
         if (c >= 2 && c <= 9) begin
            ea = vbase + 20'((ptr0 + c - 2) % FW);
            check("vdata", vdata, word(ea));
         end
      end
      vsync = 1'b0;
      wr    = 1'b0;
      rd    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", stallX, 0);
      check("rst_vvalid", vvalid, 0);
      check("rst_vdata", vdata, 0);
      rst = 1'b0;
      @(negedge clk);
      wr = 1'b1; adr = 24'h000104; outbus = 32'h12345678; #1;
      check("first_we", sram_we, 1);
      check("first_adr", sram_adr, 20'h00041);
      wr = 1'b0;

      // single burst from word 0 at vbase 0x10000, CPU strobes ignored
      burst_watch(0, 1'b0, 0);

      // vreq held: exactly one CPU cycle between bursts
      @(negedge clk);
      vreq = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); #1;
         check("hold_stall", stallX, 1);
      end
      @(negedge clk);
      wr = 1'b1; ben = 1'b0; adr = 24'h000104; outbus = 32'hDEADBEEF; #1;
      check("gap_stall", stallX, 0);
      check("gap_we", sram_we, 1);
      check("gap_adr", sram_adr, 20'h00041);
      check("gap_be", sram_be, 4'hF);
      check("gap_dout", sram_dout, 32'hDEADBEEF);
      #2 wr = 1'b0;
      @(negedge clk);
      vreq = 1'b0; #1;
      check("b2_stall", stallX, 1);
      check("b2_adr", sram_adr, 20'h10010);
      repeat (9) @(negedge clk);
      #1 check("b2_done", stallX, 0);

      // byte enables and CPU reads in IDLE
      @(negedge clk);
      ben = 1'b1; wr = 1'b1; adr = 24'h000007; outbus = 32'h000000A5; #1;
      check("be_lane3", sram_be, 4'b1000);
      check("be_adr", sram_adr, 20'h00001);
      check("be_dout", sram_dout, 32'h000000A5);
      check("be_we", sram_we, 1);
      @(negedge clk);
      wr = 1'b0; rd = 1'b1; adr = 24'h000106; #1;
      check("rd_be", sram_be, 4'b0100);
      check("rd_inbus", inbus, word(20'h00041));
      check("rd_we", sram_we, 0);
      @(negedge clk);
      adr = 24'h000010; #1;
      check("be_lane0", sram_be, 4'b0001);
      rd = 1'b0; ben = 1'b0;

      // vsync mid-burst: no disturbance, next burst restarts at vbase
      burst_watch(24, 1'b0, 4);
      burst_watch(0, 1'b0, 0);
      // vsync together with vreq: pointer cleared before the burst
      burst_watch(0, 1'b1, 0);
      // 20-bit address wrap across vbase + vptr
      vbase = 20'hFFFF4;
      burst_watch(8, 1'b0, 0);
      vbase = 20'h10000;

      // reset at beat 5
      @(negedge clk);
      vreq = 1'b1;
      @(negedge clk);
      vreq = 1'b0;
      repeat (5) @(negedge clk);
      #1 check("r_beat5_adr", sram_adr, 20'h10015);
      rst = 1'b1;
      @(negedge clk); #1;
      check("r_stall", stallX, 0);
      check("r_vvalid", vvalid, 0);
      check("r_vdata", vdata, 0);
      rst = 1'b0;
      burst_watch(0, 1'b0, 0);

      // frame wrap on a 20-word frame: 16..19 then 0..3 within one burst
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         vreq2 = 1'b1;
         @(negedge clk);
         vreq2 = 1'b0;
         repeat (9) @(negedge clk);
      end
      @(negedge clk);
      vreq2 = 1'b1;
      @(negedge clk);
      vreq2 = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) @(negedge clk);
         #1;
         check("wrap_stall", stall2, 1);
         check("wrap_adr", sram_adr2, 20'h00100 + 20'((16 + c - 1) % 20));
      end
      @(negedge clk); #1;
      check("wrap_last_vdata", vdata2, word(20'h00103));
      check("wrap_done", stall2, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
